// File: rtl/arm_dmem_arbiter.sv
// rtl/arm_dmem_arbiter.sv - CPU/debug arbiter for the single-port synchronous-read data memory
// CPU has default priority; a saturating wait counter forces the debug port through after MAX_WAIT denials.
module arm_dmem_arbiter #(
    parameter int AW       = 6,
    parameter int MAX_WAIT = 4
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_rvalid,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [31:0]   dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [31:0]   dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        DBG_RD = 2'd2
    } state_t;

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  w_wait_next;
    logic [31:0] r_cpu_rdata;
    logic [31:0] r_dbg_rdata;
    logic        w_cpu_elig;
    logic        w_force;
    logic        w_dbg_win;
    logic        w_cpu_win;

    // Grants are suppressed while RESETn is low so nothing reaches the memory during reset.
    always_comb begin
        w_cpu_elig = cpu_req && (r_state != CPU_RD);
        w_force    = (r_wait_cnt == LP_MAX_WAIT);
        w_dbg_win  = RESETn && dbg_req && (w_force || !w_cpu_elig);
        w_cpu_win  = RESETn && w_cpu_elig && !w_dbg_win;
    end

    always_comb begin
        w_next_state = IDLE;
        w_wait_next  = r_wait_cnt;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (w_dbg_win) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            if (!dbg_we) begin
                w_next_state = DBG_RD;
            end
        end else if (w_cpu_win) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            if (!cpu_we) begin
                w_next_state = CPU_RD;
            end
        end
        if (w_dbg_win || !dbg_req) begin
            w_wait_next = '0;
        end else if (r_wait_cnt != LP_MAX_WAIT) begin
            w_wait_next = r_wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_next;
            if (r_state == CPU_RD) begin
                r_cpu_rdata <= mem_rdata;
            end
            if (r_state == DBG_RD) begin
                r_dbg_rdata <= mem_rdata;
            end
        end
    end

    // Return cycles pass memory data straight through; the registers hold it afterwards.
    always_comb begin
        cpu_rvalid = (r_state == CPU_RD);
        dbg_rvalid = (r_state == DBG_RD);
        cpu_rdata  = cpu_rvalid ? mem_rdata : r_cpu_rdata;
        dbg_rdata  = dbg_rvalid ? mem_rdata : r_dbg_rdata;
        dbg_gnt    = w_dbg_win;
        cpu_stall  = w_cpu_elig && (!w_cpu_win || !cpu_we);
    end

endmodule

// File: tb/tb_arm_dmem_arbiter.sv
// tb/tb_arm_dmem_arbiter.sv - scoreboard bench for arm_dmem_arbiter with a behavioural reference model
module tb_arm_dmem_arbiter;

    localparam int AW       = 6;
    localparam int MAX_WAIT = 4;

    logic          CLK = 1'b0;
    logic          RESETn;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [31:0]   cpu_wdata, dbg_wdata;
    logic [31:0]   cpu_rdata, dbg_rdata;
    logic          cpu_rvalid, cpu_stall, dbg_gnt, dbg_rvalid;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    arm_dmem_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    // Physical single-port memory with synchronous read
    logic [31:0] phys_mem [64];
    always @(posedge CLK) begin
        if (mem_en && mem_we) phys_mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= phys_mem[mem_addr];
    end

    typedef struct packed {
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          stall;
        logic          gnt;
        logic          crv;
        logic          drv;
        logic [31:0]   chold;
        logic [31:0]   dhold;
    } exp_t;

    exp_t        ctl_q[$];
    logic [31:0] cpu_q[$];
    logic [31:0] dbg_q[$];

    // Reference model state
    logic [31:0] ref_mem [64];
    bit          m_cpu_inf, m_dbg_inf;
    int          m_wait;
    logic [31:0] m_cpu_pend, m_dbg_pend, m_cpu_last, m_dbg_last;
    bit          mdl_stall, mdl_gnt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
        end
    endtask

    // Monitor: pops one expectation per cycle, and read data whenever the DUT asserts rvalid
    always @(negedge CLK) begin
        exp_t e;
        logic [31:0] d;
        if (ctl_q.size() > 0) begin
            e = ctl_q.pop_front();
            chk("mem_en", 32'(mem_en), 32'(e.en));
            chk("mem_we", 32'(mem_we), 32'(e.we));
            chk("mem_addr", 32'(mem_addr), 32'(e.addr));
            chk("mem_wdata", mem_wdata, e.wdata);
            chk("cpu_stall", 32'(cpu_stall), 32'(e.stall));
            chk("dbg_gnt", 32'(dbg_gnt), 32'(e.gnt));
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e.crv));
            chk("dbg_rvalid", 32'(dbg_rvalid), 32'(e.drv));
            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) chk("cpu_rdata_unexpected", 32'd1, 32'd0);
                else begin
                    d = cpu_q.pop_front();
                    chk("cpu_rdata", cpu_rdata, d);
                end
            end else begin
                chk("cpu_rdata_hold", cpu_rdata, e.chold);
            end
            if (dbg_rvalid) begin
                if (dbg_q.size() == 0) chk("dbg_rdata_unexpected", 32'd1, 32'd0);
                else begin
                    d = dbg_q.pop_front();
                    chk("dbg_rdata", dbg_rdata, d);
                end
            end else begin
                chk("dbg_rdata_hold", dbg_rdata, e.dhold);
            end
        end
    end

    // Predicts the current cycle from the arbitration rules, then advances one clock.
    task automatic step();
        exp_t e;
        bit   celig, dwin, cwin;
        e = '0;
        if (!RESETn) begin
            e.stall    = cpu_req;
            m_cpu_inf  = 0;
            m_dbg_inf  = 0;
            m_wait     = 0;
            m_cpu_last = '0;
            m_dbg_last = '0;
            cpu_q.delete();
            dbg_q.delete();
            mdl_stall  = cpu_req;
            mdl_gnt    = 0;
        end else begin
            e.crv   = m_cpu_inf;
            e.drv   = m_dbg_inf;
            e.chold = m_cpu_last;
            e.dhold = m_dbg_last;
            if (m_cpu_inf) m_cpu_last = m_cpu_pend;
            if (m_dbg_inf) m_dbg_last = m_dbg_pend;
            celig = cpu_req && !m_cpu_inf;
            dwin  = dbg_req && (m_wait == MAX_WAIT || !celig);
            cwin  = celig && !dwin;
            m_cpu_inf = 0;
            m_dbg_inf = 0;
            if (dwin) begin
                e.en = 1; e.we = dbg_we; e.addr = dbg_addr; e.wdata = dbg_wdata;
                if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
                else begin
                    m_dbg_pend = ref_mem[dbg_addr];
                    dbg_q.push_back(m_dbg_pend);
                    m_dbg_inf = 1;
                end
            end else if (cwin) begin
                e.en = 1; e.we = cpu_we; e.addr = cpu_addr; e.wdata = cpu_wdata;
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
                else begin
                    m_cpu_pend = ref_mem[cpu_addr];
                    cpu_q.push_back(m_cpu_pend);
                    m_cpu_inf = 1;
                end
            end
            e.gnt   = dwin;
            e.stall = celig && !(cwin && cpu_we);
            if (dwin || !dbg_req) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
            mdl_stall = e.stall;
            mdl_gnt   = dwin;
        end
        ctl_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    // Runs cycles, dropping each request once the model says it has been served.
    task automatic settle(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            if (!mdl_stall) cpu_req = 0;
            if (mdl_gnt) dbg_req = 0;
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 6'h19 : 6'(r);
    endfunction

    initial begin
        bit c_hold, d_hold;
        for (int i = 0; i < 64; i++) begin
            phys_mem[i] = 32'h1000_0000 + i * 32'h0101;
            ref_mem[i]  = 32'h1000_0000 + i * 32'h0101;
        end
        RESETn  = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        @(posedge CLK);
        #1;
        step();
        step();
        RESETn = 1;
        step();

        // CPU store then load
        cpu_req = 1; cpu_we = 1; cpu_addr = 6'h19; cpu_wdata = 32'h0000_0007;
        settle(1);
        cpu_req = 1; cpu_we = 0;
        settle(3);

        // DBG write then read with CPU idle
        dbg_req = 1; dbg_we = 1; dbg_addr = 6'h05; dbg_wdata = 32'hDEAD_BEEF;
        settle(1);
        dbg_req = 1; dbg_we = 0;
        settle(3);

        // Starvation: continuous CPU stores, DBG read held
        cpu_req = 1; cpu_we = 1; cpu_addr = 6'h01;
        dbg_req = 1; dbg_we = 0; dbg_addr = 6'h02;
        for (int k = 0; k < 5; k++) begin
            cpu_wdata = $urandom;
            step();
        end
        cpu_req = 0; dbg_req = 0;
        settle(2);

        // Slot reuse during CPU_RD
        cpu_req = 1; cpu_we = 0; cpu_addr = 6'h19;
        dbg_req = 1; dbg_we = 0; dbg_addr = 6'h05;
        settle(4);

        // Reset in the CPU_RD cycle, then a clean load
        cpu_req = 1; cpu_we = 0; cpu_addr = 6'h19;
        step();
        RESETn = 0;
        step();
        cpu_req = 0;
        step();
        RESETn = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 6'h19;
        settle(3);

        // Same-address race: CPU load vs DBG write
        cpu_req = 1; cpu_we = 0; cpu_addr = 6'h19;
        dbg_req = 1; dbg_we = 1; dbg_addr = 6'h19; dbg_wdata = 32'hA5A5_0019;
        settle(2);
        cpu_req = 1; cpu_we = 0; cpu_addr = 6'h19;
        settle(3);

        // Randomized traffic obeying the hold-until-served protocol
        c_hold = 0;
        d_hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (!c_hold) begin
                cpu_req = ($urandom_range(0, 9) < 6);
                cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = rand_addr();
                cpu_wdata = $urandom;
            end
            if (!d_hold) begin
                dbg_req = ($urandom_range(0, 9) < 5);
                dbg_we = 1'($urandom_range(0, 1));
                dbg_addr = rand_addr();
                dbg_wdata = $urandom;
            end
            step();
            c_hold = mdl_stall;
            d_hold = dbg_req && !mdl_gnt;
        end
        cpu_req = 0;
        dbg_req = 0;
        settle(3);
        chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        chk("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
        chk("ctl_q_drained", 32'(ctl_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arm_dmem_arbiter.md
Name: arm_dmem_arbiter

Overview:
- Shares the single-port, synchronous-read data memory between the ARM single-cycle core's load/store port (CPU) and a debug/loader port (DBG).
- The CPU has default priority. A starvation counter guarantees DBG a slot after MAX_WAIT denied cycles.
- The core is frozen through cpu_stall while it waits for a grant or for read data.
- Sits between the core's data-memory interface and the data memory in the arm top level.

Parameters:
- AW, 6, word-address width (64 x 32-bit words).
- MAX_WAIT, 4, number of consecutive denied DBG cycles before DBG is forced ahead of the CPU (range 1..15).

Ports:
- CLK  input  1  clock, rising edge.
- RESETn  input  1  asynchronous reset, active low.
- cpu_req  input  1  core requests a data access this cycle (LDR/STR).
- cpu_we  input  1  1 = store, 0 = load.
- cpu_addr  input  AW  core word address.
- cpu_wdata  input  32  store data.
- cpu_rdata  output  32  load data; valid when cpu_rvalid = 1.
- cpu_rvalid  output  1  load data returned this cycle.
- cpu_stall  output  1  freeze core PC/register write this cycle.
- dbg_req  input  1  debug access request; held until dbg_gnt.
- dbg_we  input  1  1 = write, 0 = read.
- dbg_addr  input  AW  debug word address.
- dbg_wdata  input  32  debug write data.
- dbg_gnt  output  1  one-cycle pulse: request accepted this cycle.
- dbg_rvalid  output  1  debug read data valid (cycle after grant).
- dbg_rdata  output  32  debug read data.
- mem_en  output  1  memory access enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data, valid the cycle after mem_en with mem_we = 0.

Behaviour:
- States: IDLE, CPU_RD (CPU read data returning), DBG_RD (DBG read data returning).
- A new memory operation may be issued in any state, so the port is pipelined.
- Arbitration each cycle:
  - Eligible CPU: cpu_req and state != CPU_RD. The CPU's load is already in flight during CPU_RD.
  - force = (wait_cnt == MAX_WAIT).
  - Winner is DBG if dbg_req and (force or no eligible CPU); otherwise CPU if eligible.
- Issue: the winner's we/addr/wdata are driven combinationally onto mem_*, with mem_en = 1. With no winner, mem_en = 0 and mem_we = 0. mem_addr and mem_wdata are then don't-care; drive 0.
- Next state:
  - CPU read win -> CPU_RD.
  - DBG read win -> DBG_RD.
  - Otherwise -> IDLE.
- CPU timing:
  - A granted store completes the same cycle, with cpu_stall = 0.
  - A granted load has cpu_stall = 1 in the issue cycle. The next cycle (CPU_RD) has cpu_rvalid = 1, cpu_rdata = mem_rdata and cpu_stall = 0.
  - A denied CPU request has cpu_stall = 1 and the core retries with the same signals.
  - cpu_stall is combinational: cpu_req and (denied, or load issued this cycle).
- DBG timing:
  - dbg_gnt = 1 in the issue cycle.
  - For a read, dbg_rvalid = 1 and dbg_rdata = mem_rdata in the following cycle (DBG_RD).
- wait_cnt:
  - Reset to 0.
  - Cleared on dbg_gnt or when dbg_req = 0.
  - Incremented when dbg_req and not granted, saturating at MAX_WAIT.
- cpu_rdata and dbg_rdata are registered copies of mem_rdata, captured in CPU_RD and DBG_RD respectively. They hold their value otherwise.
- Hazards: same-address accesses are serialized in grant order; no forwarding.
- Reset (async, any state): state = IDLE, wait_cnt = 0, cpu_rdata = 0, dbg_rdata = 0.
- Outputs after reset:
  - cpu_rvalid = 0, dbg_rvalid = 0, dbg_gnt = 0, mem_en = 0, mem_we = 0.
  - cpu_stall follows cpu_req while RESETn is low. An in-flight read is discarded with no rvalid.

Test Plan:
- CPU store then load: store 0x00000007 to addr 0x19, then load 0x19 -> store has cpu_stall = 0. Load has cpu_stall = 1 for one cycle, then cpu_rvalid = 1 with cpu_rdata = 0x00000007.
- Idle-CPU DBG access: DBG write 0xDEADBEEF to addr 0x05, then DBG read 0x05 -> dbg_gnt on each. dbg_rvalid = 1 with dbg_rdata = 0xDEADBEEF one cycle after the read grant.
- Starvation (MAX_WAIT = 4): cpu_req stores held continuously, dbg_req held -> DBG denied for 4 cycles. dbg_gnt in cycle 5 with cpu_stall = 1 that cycle. wait_cnt returns to 0.
- Slot reuse: CPU load issued in cycle N and DBG read pending -> DBG granted in cycle N+1 (CPU_RD) while cpu_rvalid = 1. dbg_rvalid = 1 in cycle N+2.
- Reset mid-read: assert RESETn low in a CPU_RD cycle -> cpu_rvalid = 0 immediately, mem_en = 0, state IDLE. After release, a load of 0x19 returns the correct data.
- Same-address race: CPU load and DBG write to 0x19 requested together (wait_cnt = 0) -> CPU wins and reads the old value. The DBG write is granted the next cycle.
